// File: rtl/axis_width_upsizer_pkg.sv
// Shared constants and lane helpers for the AXI-Stream width upsizer.
package axis_width_upsizer_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_RATIO      = 4;

    // Bit offset of a DATA_WIDTH-wide lane inside the packed output word.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/axis_width_upsizer.sv
// Packs RATIO narrow AXI-Stream beats into one wide word, flushing early on tlast.
module axis_width_upsizer
    import axis_width_upsizer_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int RATIO      = DEFAULT_RATIO,
    parameter int OUT_WIDTH  = DATA_WIDTH * RATIO,
    parameter int KEEP_WIDTH = RATIO,
    parameter int CNT_W      = $clog2(RATIO)
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [DATA_WIDTH-1:0] m_tdata,
    input  logic                  m_tvalid,
    output logic                  m_tready,
    input  logic                  m_tlast,
    output logic [OUT_WIDTH-1:0]  s_tdata,
    output logic [KEEP_WIDTH-1:0] s_tkeep,
    output logic                  s_tvalid,
    input  logic                  s_tready,
    output logic                  s_tlast
);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0]  pack_q, pack_d;
    logic [OUT_WIDTH-1:0]  out_data_q, out_data_d;
    logic [KEEP_WIDTH-1:0] out_keep_q, out_keep_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;

    logic [OUT_WIDTH-1:0]  word_merged;
    logic [KEEP_WIDTH-1:0] keep_mask;
    logic                  accept;
    logic                  complete;

    // Ready depends only on registered output state, never on m_tvalid/m_tlast.
    assign m_tready = !areset && (!out_valid_q || s_tready);
    assign accept   = m_tvalid && m_tready;
    assign complete = accept && ((cnt_q == CNT_W'(RATIO - 1)) || m_tlast);

    // Lane gi takes the incoming beat when it is the current fill position.
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
        localparam int LSB = lane_lsb(gi, DATA_WIDTH);
        assign word_merged[LSB +: DATA_WIDTH] =
            (cnt_q == CNT_W'(gi)) ? m_tdata : pack_q[LSB +: DATA_WIDTH];
        assign keep_mask[gi] = ({{(32 - CNT_W){1'b0}}, cnt_q} >= 32'(gi));
    end

    always_comb begin
        cnt_d       = cnt_q;
        pack_d      = pack_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        // Pack register is cleared on completion so lanes above the flush point read as zero.
        if (complete) begin
            cnt_d  = '0;
            pack_d = '0;
        end else if (accept) begin
            cnt_d  = cnt_q + CNT_W'(1);
            pack_d = word_merged;
        end

        if (complete) begin
            out_valid_d = 1'b1;
            out_data_d  = word_merged;
            out_keep_d  = keep_mask;
            out_last_d  = m_tlast;
        end else if (out_valid_q && s_tready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            cnt_q       <= '0;
            pack_q      <= '0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            pack_q      <= pack_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign s_tdata  = out_data_q;
    assign s_tkeep  = out_keep_q;
    assign s_tvalid = out_valid_q;
    assign s_tlast  = out_last_q;

endmodule

// File: tb/tb_axis_width_upsizer.sv
// Directed bench for axis_width_upsizer (8-bit beats, ratio 4) with a byte-list reference model.
module tb_axis_width_upsizer;

    logic        clk = 1'b0;
    logic        areset;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic [31:0] s_tdata;
    logic [3:0]  s_tkeep;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    axis_width_upsizer #(.DATA_WIDTH(8), .RATIO(4)) dut (
        .aclk     (clk),
        .areset   (areset),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tlast  (m_tlast),
        .s_tdata  (s_tdata),
        .s_tkeep  (s_tkeep),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tlast  (s_tlast)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a list of accepted bytes becomes a word once 4 are held or tlast arrives.
    logic [7:0]  beats[$];
    logic        mv = 1'b0;
    logic        ml = 1'b0;
    logic [31:0] md = '0;
    logic [3:0]  mk = '0;
    logic        started = 1'b0;

    logic [31:0] got_data[$];
    logic [3:0]  got_keep[$];
    logic        got_last[$];

    always @(posedge clk) begin
        logic acc, drained;
        started = 1'b1;
        if (s_tvalid === 1'b1 && s_tready) begin
            got_data.push_back(s_tdata);
            got_keep.push_back(s_tkeep);
            got_last.push_back(s_tlast);
            $display("[TB] word %0d: data=%h keep=%b last=%b", got_data.size(), s_tdata, s_tkeep, s_tlast);
        end
        if (areset) begin
            beats.delete();
            mv = 1'b0; ml = 1'b0; md = '0; mk = '0;
        end else begin
            acc     = m_tvalid && (!mv || s_tready);
            drained = mv && s_tready;
            if (acc) beats.push_back(m_tdata);
            if (acc && (beats.size() == 4 || m_tlast)) begin
                md = '0;
                for (int i = 0; i < beats.size(); i++) md[i*8 +: 8] = beats[i];
                mk = 4'((1 << beats.size()) - 1);
                ml = m_tlast;
                mv = 1'b1;
                beats.delete();
            end else if (drained) begin
                mv = 1'b0;
                ml = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, plus the hold-stability rule.
    logic        prev_hold = 1'b0;
    logic [31:0] prev_data;
    logic [3:0]  prev_keep;
    logic        prev_last;
    int          ready_low_cnt = 0;

    always @(negedge clk) begin
        if (started) begin
            chk("m_tready", 64'(m_tready), 64'(!areset && (!mv || s_tready)));
            if (!areset) begin
                chk("s_tvalid", 64'(s_tvalid), 64'(mv));
                if (mv) begin
                    chk("s_tdata", 64'(s_tdata), 64'(md));
                    chk("s_tkeep", 64'(s_tkeep), 64'(mk));
                    chk("s_tlast", 64'(s_tlast), 64'(ml));
                end
                if (prev_hold) begin
                    chk("hold_data", 64'(s_tdata), 64'(prev_data));
                    chk("hold_keep", 64'(s_tkeep), 64'(prev_keep));
                    chk("hold_last", 64'(s_tlast), 64'(prev_last));
                end
            end
            if (!m_tready) ready_low_cnt++;
            prev_hold = !areset && s_tvalid && !s_tready;
            prev_data = s_tdata;
            prev_keep = s_tkeep;
            prev_last = s_tlast;
        end
    end

    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        m_tvalid = 1'b1; m_tdata = d; m_tlast = l;
        forever begin
            @(posedge clk);
            if (m_tready) break;
            n++;
            if (n > 100) begin
                tests++; failed++;
                $display("FAIL send_timeout: beat %h not accepted within 100 cycles", d);
                break;
            end
        end
    endtask

    task automatic idle();
        @(negedge clk);
        m_tvalid = 1'b0; m_tlast = 1'b0;
    endtask

    task automatic chk_word(input string name, input int idx,
                            input logic [31:0] d, input logic [3:0] k, input logic l);
        if (got_data.size() <= idx) begin
            tests++; failed++;
            $display("FAIL %s: only %0d words seen, required index %0d", name, got_data.size(), idx);
        end else begin
            chk({name, "_data"}, 64'(got_data[idx]), 64'(d));
            chk({name, "_keep"}, 64'(got_keep[idx]), 64'(k));
            chk({name, "_last"}, 64'(got_last[idx]), 64'(l));
        end
    endtask

    initial begin
        int base;
        // 1: reset with m_tvalid high
        areset = 1'b1; m_tvalid = 1'b1; m_tdata = 8'hEE; m_tlast = 1'b0; s_tready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_m_tready", 64'(m_tready), 64'd0);
        chk("reset_s_tvalid", 64'(s_tvalid), 64'd0);
        chk("reset_s_tkeep", 64'(s_tkeep), 64'd0);
        chk("reset_s_tlast", 64'(s_tlast), 64'd0);
        m_tvalid = 1'b0; areset = 1'b0;
        @(negedge clk);

        // 2: full word, one cycle latency
        base = got_data.size();
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 1);
        idle();
        chk("full_latency_valid", 64'(s_tvalid), 64'd1);
        chk("full_latency_data", 64'(s_tdata), 64'h44332211);
        repeat (2) @(negedge clk);
        chk_word("full", base, 32'h44332211, 4'hF, 1'b1);

        // 3: partial flush
        base = got_data.size();
        send(8'hA1, 0); send(8'hB2, 1);
        idle();
        repeat (2) @(negedge clk);
        chk_word("partial", base, 32'h0000B2A1, 4'h3, 1'b1);

        // Single-beat packet
        base = got_data.size();
        send(8'h5A, 1);
        idle();
        repeat (2) @(negedge clk);
        chk_word("single", base, 32'h0000005A, 4'h1, 1'b1);

        // 4: backpressure
        base = got_data.size();
        s_tready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 8; i++) send(8'(i), i == 8);
                idle();
            end
            begin
                repeat (6) @(negedge clk);
                s_tready = 1'b1;
            end
        join
        repeat (3) @(negedge clk);
        chk_word("bp0", base, 32'h04030201, 4'hF, 1'b0);
        chk_word("bp1", base + 1, 32'h08070605, 4'hF, 1'b1);

        // 5: streaming, m_tready must never drop
        base = got_data.size();
        ready_low_cnt = 0;
        for (int i = 0; i < 16; i++) send(8'(8'h10 + i), i == 15);
        idle();
        chk("stream_ready_drops", 64'(ready_low_cnt), 64'd0);
        repeat (2) @(negedge clk);
        chk_word("stream0", base, 32'h13121110, 4'hF, 1'b0);
        chk_word("stream3", base + 3, 32'h1F1E1D1C, 4'hF, 1'b1);
        chk("stream_count", 64'(got_data.size() - base), 64'd4);

        // 6: mid-word reset discards the partial word
        base = got_data.size();
        send(8'hC1, 0); send(8'hC2, 0);
        @(negedge clk);
        m_tvalid = 1'b0; areset = 1'b1;
        @(negedge clk);
        areset = 1'b0;
        send(8'h05, 0); send(8'h06, 0); send(8'h07, 0); send(8'h08, 1);
        idle();
        repeat (2) @(negedge clk);
        chk("midreset_count", 64'(got_data.size() - base), 64'd1);
        chk_word("midreset", base, 32'h08070605, 4'hF, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
